token_credit_buffer: RTL

- Buffers single-cycle token pulses, such as the output of the token-halving stage, as a saturating credit count.
- Releases stored tokens one at a time to a downstream consumer over a valid/ready handshake.
- Enforces a minimum idle gap between released tokens.
- Sits directly downstream of the halving stage and decouples its bursty output from a back-pressuring consumer.

---
 rtl/token_credit_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/token_credit_buffer.sv
// token_credit_buffer
// Stores incoming single-cycle token pulses as a saturating credit count and
// releases them one at a time over a valid/ready handshake, with a forced
// idle gap after every release. All outputs decode registered state only.

module token_credit_buffer #(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a,
    output logic                       b,
    input  logic                       b_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [GW-1:0] MIN_GAP_C = GW'(MIN_GAP);
    localparam logic [GW-1:0] GAP_ONE   = GW'(1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        OFFER = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_nxt;
    logic [CW-1:0] count_nxt;
    logic          overflow_nxt;
    logic          xfer;

    // State register plus the credit counter, gap timer and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            count    <= '0;
            gap_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            gap_cnt  <= gap_nxt;
            overflow <= overflow_nxt;
        end
    end

    // Next-state logic: token arrival, release on handshake, and gap countdown
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        gap_nxt      = gap_cnt;
        overflow_nxt = overflow;
        xfer         = (state == OFFER) && b_ready;

        // An arriving token paired with a release leaves the count unchanged,
        // so it is never dropped even when the buffer is full.
        if (a && !xfer) begin
            if (count == DEPTH_C) begin
                overflow_nxt = 1'b1;
            end else begin
                count_nxt = count + CNT_ONE;
            end
        end else if (xfer && !a) begin
            count_nxt = count - CNT_ONE;
        end

        unique case (state)
            EMPTY: begin
                if (a) begin
                    state_nxt = (gap_cnt == '0) ? OFFER : GAP;
                end
            end
            OFFER: begin
                if (xfer) begin
                    gap_nxt = MIN_GAP_C;
                    if (MIN_GAP > 0) begin
                        state_nxt = GAP;
                    end else begin
                        state_nxt = (count_nxt != '0) ? OFFER : EMPTY;
                    end
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - GAP_ONE;
                if (gap_cnt == GAP_ONE) begin
                    state_nxt = (count_nxt != '0) ? OFFER : EMPTY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        b    = (state == OFFER);
        full = (count == DEPTH_C);
    end

endmodule
